normalizare_secv: RTL

- Sequential post-add normalizer for the floating-point adder datapath.
- Consumes the raw sum mantissa (with carry bit) and the pre-normalization exponent held in the mantissa/exponent registers.
- Shifts the mantissa one bit per cycle until its MSB is 1, adjusting the exponent at each shift.
- Returns a normalized mantissa, a normalized exponent and status flags to the result-packing stage through a start/done handshake.

---
 rtl/normalizare_secv.sv | 131 +++++++++++++
 1 files changed

// File: rtl/normalizare_secv.sv
// Sequential post-add normalizer: shifts the raw sum mantissa one bit per cycle until normalized.
// Optional macro NORM_SHIFT_CNT_EN adds the shift_cnt output (number of left shifts).
module normalizare_secv #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [MANT_W:0]   mantisa,
    input  logic [EXP_W-1:0]  exponent,
    output logic              busy,
    output logic              done,
    output logic [MANT_W-1:0] mant_norm,
    output logic [EXP_W-1:0]  exp_norm,
    output logic              zero,
    output logic              overflow,
    output logic              underflow
`ifdef NORM_SHIFT_CNT_EN
    ,
    output logic [$clog2(MANT_W):0] shift_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, EVAL, LEFT, DONE} state_t;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
    localparam logic [EXP_W-1:0] EXP_TWO = EXP_W'(2);

    state_t            state;
    logic [MANT_W:0]   mant;
    logic [EXP_W-1:0]  exp_w;

    // NOTE: all state lives in one clocked block and uses non-blocking assignments,
    // so every register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            mant      <= '0;
            exp_w     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mant_norm <= '0;
            exp_norm  <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef NORM_SHIFT_CNT_EN
            shift_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mant      <= mantisa;
                        exp_w     <= exponent;
                        zero      <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        busy      <= 1'b1;
`ifdef NORM_SHIFT_CNT_EN
                        shift_cnt <= '0;
`endif
                        state     <= EVAL;
                    end
                end

                EVAL: begin
                    if (mant == '0) begin
                        exp_w <= '0;
                        zero  <= 1'b1;
                        state <= DONE;
                    end else if (mant[MANT_W]) begin
                        // An all-ones input exponent is also caught here so it never wraps.
                        if (exp_w >= EXP_MAX - 1'b1) begin
                            mant     <= '0;
                            exp_w    <= EXP_MAX;
                            overflow <= 1'b1;
                        end else begin
                            mant  <= mant >> 1;
                            exp_w <= exp_w + 1'b1;
                        end
                        state <= DONE;
                    end else if (mant[MANT_W-1]) begin
                        state <= DONE;
                    end else begin
                        state <= LEFT;
                    end
                end

                LEFT: begin
                    if (mant[MANT_W-1]) begin
                        state <= DONE;
                    end else if (exp_w <= EXP_ONE) begin
                        exp_w     <= '0;
                        underflow <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mant  <= mant << 1;
                        exp_w <= exp_w - 1'b1;
`ifdef NORM_SHIFT_CNT_EN
                        shift_cnt <= shift_cnt + 1'b1;
`endif
                        // Look one shift ahead so the terminating shift also leaves LEFT;
                        // this keeps latency at exactly one edge per shift.
                        if (mant[MANT_W-2]) begin
                            state <= DONE;
                        end else if (exp_w == EXP_TWO) begin
                            exp_w     <= '0;
                            underflow <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    mant_norm <= mant[MANT_W-1:0];
                    exp_norm  <= exp_w;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
